// File: rtl/shift_register_seq.sv
// shift_register_seq
// Self-sequencing shift register for the shift-add multiplier datapath.
// A WORD_LENGTH operand is loaded zero-extended into a WORD-wide register.
// A start request performs shiftCount single-bit shifts autonomously and then
// pulses done for one cycle. Single manual shifts are accepted while idle.
//
// Optional feature macro: SHIFT_ROTATE_EN
//   defined     : rotate=1 feeds the ejected bit back in as the fill bit
//                 (overrides arith).
//   not defined : the rotate port is accepted but has no effect.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   load           load zero-extended parallelInput (idle only)
//   start          begin automatic sequence of shiftCount shifts (idle only)
//   shift          single manual shift (idle only)
//   dir            0 = left (toward MSB), 1 = right
//   arith          right shift fills MSB with the sign bit
//   rotate         rotate mode (SHIFT_ROTATE_EN builds only)
//   serialInput    fill bit for logical shifts, sampled live every shift
//   shiftCount     number of shifts for a start
//   parallelInput  operand
//   busy           high while the automatic sequence is running
//   done           one-cycle pulse when a sequence completes
//   serialOutput   bit the next shift ejects (direction of the last shift)
//   parallelOutput register contents
//
// States:
//   IDLE  | accepts load / start / shift (priority in that order)
//   SHIFT | one shift per clock with latched controls, counter counts down
//   DONE  | one-cycle completion pulse, inputs ignored

module shift_register_seq #(
  parameter int WORD_LENGTH = 4,
  parameter int WORD        = WORD_LENGTH * 2,
  parameter int COUNT_W     = $clog2(WORD + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   start,
  input  logic                   shift,
  input  logic                   dir,
  input  logic                   arith,
  input  logic                   rotate,
  input  logic                   serialInput,
  input  logic [COUNT_W-1:0]     shiftCount,
  input  logic [WORD_LENGTH-1:0] parallelInput,
  output logic                   busy,
  output logic                   done,
  output logic                   serialOutput,
  output logic [WORD-1:0]        parallelOutput
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WORD-1:0]    data;
  logic [COUNT_W-1:0] counter;
  logic               dir_reg;
  logic               arith_reg;
  logic               manual_fill;
  logic               auto_fill;

`ifdef SHIFT_ROTATE_EN
  logic               rot_reg;
`else
  logic               rotate_unused;
  assign rotate_unused = rotate;
`endif

  // Default fill: serialInput, except an arithmetic right shift replicates
  // the sign bit.
  function automatic logic calc_fill(input logic [WORD-1:0] v,
                                     input logic d,
                                     input logic a,
                                     input logic si);
    logic f;
    f = si;
    if (d && a) f = v[WORD-1];
    return f;
  endfunction

  function automatic logic [WORD-1:0] shift_step(input logic [WORD-1:0] v,
                                                 input logic d,
                                                 input logic f);
    logic [WORD-1:0] r;
    if (d) r = {f, v[WORD-1:1]};
    else   r = {v[WORD-2:0], f};
    return r;
  endfunction

  // Manual shifts use the live controls, the automatic sequence the latched
  // ones; serialInput is live in both cases so bits can be streamed in.
  always_comb begin
    manual_fill = calc_fill(data, dir, arith, serialInput);
    auto_fill   = calc_fill(data, dir_reg, arith_reg, serialInput);
`ifdef SHIFT_ROTATE_EN
    if (rotate)  manual_fill = dir     ? data[0] : data[WORD-1];
    if (rot_reg) auto_fill   = dir_reg ? data[0] : data[WORD-1];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      data      <= '0;
      counter   <= '0;
      dir_reg   <= 1'b0;
      arith_reg <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            data <= WORD'(parallelInput);
          end else if (start) begin
            if (shiftCount != '0) begin
              counter   <= shiftCount;
              dir_reg   <= dir;
              arith_reg <= arith;
`ifdef SHIFT_ROTATE_EN
              rot_reg   <= rotate;
`endif
              state     <= SHIFT;
            end else begin
              state <= DONE;
            end
          end else if (shift) begin
            data    <= shift_step(data, dir, manual_fill);
            dir_reg <= dir;
          end
        end
        SHIFT: begin
          data    <= shift_step(data, dir_reg, auto_fill);
          counter <= counter - COUNT_W'(1);
          if (counter == COUNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy           = (state == SHIFT);
  assign done           = (state == DONE);
  assign serialOutput   = dir_reg ? data[0] : data[WORD-1];
  assign parallelOutput = data;

endmodule

// File: tb/tb_shift_register_seq.sv
module tb_shift_register_seq;

  localparam int WL = 4;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0, start = 1'b0, shift = 1'b0;
  logic          dir = 1'b0, arith = 1'b0, rotate = 1'b0, serialInput = 1'b0;
  logic [CW-1:0] shiftCount = '0;
  logic [WL-1:0] parallelInput = '0;
  logic          busy, done, serialOutput;
  logic [W-1:0]  parallelOutput;

  int checks = 0;
  int failures = 0;

  // Reference model: register value as a plain integer 0..255
  int m_reg = 0;
  int m_dir = 0;

  shift_register_seq #(.WORD_LENGTH(WL)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .shift(shift),
    .dir(dir), .arith(arith), .rotate(rotate), .serialInput(serialInput),
    .shiftCount(shiftCount), .parallelInput(parallelInput),
    .busy(busy), .done(done), .serialOutput(serialOutput),
    .parallelOutput(parallelOutput)
  );

  always #5 clk = ~clk;

  function automatic int model_step(int v, int d, int a, int r, int si);
    int fill;
    fill = si;
    if (d == 1 && a == 1) fill = v / 128;
`ifdef SHIFT_ROTATE_EN
    if (r == 1) fill = (d == 1) ? (v % 2) : (v / 128);
`else
    if (r > 1) fill = 0;
`endif
    if (d == 1) return v / 2 + fill * 128;
    return (v * 2) % 256 + fill;
  endfunction

  function automatic int model_sout();
    return (m_dir == 1) ? (m_reg % 2) : (m_reg / 128);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int exp_busy, input int exp_done);
    check({tag, ".reg"},  int'(parallelOutput), m_reg);
    check({tag, ".busy"}, int'(busy), exp_busy);
    check({tag, ".done"}, int'(done), exp_done);
    check({tag, ".sout"}, int'(serialOutput), model_sout());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    parallelInput = WL'(v);
    tick();
    load = 1'b0;
    m_reg = v % 16;
    check_all("load", 0, 0);
  endtask

  task automatic do_shift(input int d, input int a, input int r, input int si);
    shift = 1'b1; dir = d[0]; arith = a[0]; rotate = r[0]; serialInput = si[0];
    tick();
    shift = 1'b0;
    m_reg = model_step(m_reg, d, a, r, si);
    m_dir = d;
    check_all("mshift", 0, 0);
  endtask

  // Automatic sequence. rand_si streams random serial bits; disturb drives
  // load/start/shift while busy and during the done cycle.
  task automatic do_seq(input int d, input int a, input int r, input int n,
                        input bit rand_si, input bit disturb);
    int si;
    start = 1'b1; dir = d[0]; arith = a[0]; rotate = r[0]; shiftCount = CW'(n);
    serialInput = 1'b0;
    tick();
    start = 1'b0;
    // latched controls must not follow the live pins
    dir = ~d[0]; arith = ~a[0]; rotate = ~r[0];
    if (n > 0) m_dir = d;
    if (n == 0) begin
      check_all("seq0", 0, 1);
    end else begin
      check_all("seq_start", 1, 0);
      for (int k = 1; k <= n; k++) begin
        si = rand_si ? int'($urandom_range(0, 1)) : 0;
        serialInput = si[0];
        if (disturb && k == 2) begin
          load = 1'b1; parallelInput = 4'h3; start = 1'b1; shift = 1'b1;
        end
        tick();
        load = 1'b0; start = 1'b0; shift = 1'b0;
        m_reg = model_step(m_reg, d, a, r, si);
        check_all("seq_step", (k < n) ? 1 : 0, (k == n) ? 1 : 0);
      end
    end
    if (disturb) begin
      load = 1'b1; parallelInput = 4'h3; start = 1'b1; shift = 1'b1;
    end
    tick();
    load = 1'b0; start = 1'b0; shift = 1'b0;
    check_all("seq_end", 0, 0);
    dir = 1'b0; arith = 1'b0; rotate = 1'b0; serialInput = 1'b0;
  endtask

  initial begin
    int op;
    // Reset state before any clock
    #2;
    check_all("reset", 0, 0);
    #10;
    reset = 1'b1;
    tick();

    // Scenario 2 + 4: load 0xB, left 4 with disturbances -> 0xB0, sout=1
    do_load(4'hB);
    do_seq(0, 0, 0, 4, 1'b0, 1'b1);
    check("s2.final", int'(parallelOutput), 8'hB0);
    check("s2.sout", int'(serialOutput), 1);

    // Scenario 3: 0x9 left 4 -> 0x90, arithmetic right 2 -> 0xE4
    do_load(4'h9);
    do_seq(0, 0, 0, 4, 1'b0, 1'b0);
    check("s3.left", int'(parallelOutput), 8'h90);
    do_seq(1, 1, 0, 2, 1'b0, 1'b0);
    check("s3.arith", int'(parallelOutput), 8'hE4);

    // Scenario 5: count 0, then manual right shift of 0x02 with si=1
    do_load(4'h2);
    do_seq(1, 0, 0, 0, 1'b0, 1'b0);
    check("s5.unchanged", int'(parallelOutput), 8'h02);
    do_shift(1, 0, 0, 1);
    check("s5.manual", int'(parallelOutput), 8'h81);

    // Scenario 6: rotate left 5 on 0x09
    do_load(4'h9);
    do_seq(0, 0, 1, 5, 1'b0, 1'b0);
`ifdef SHIFT_ROTATE_EN
    check("s6.rotate", int'(parallelOutput), 8'h21);
`else
    check("s6.rotate", int'(parallelOutput), 8'h20);
`endif

    // Count beyond the register width
    do_load(4'hF);
    do_seq(0, 0, 0, 10, 1'b0, 1'b0);
    check("wide.count", int'(parallelOutput), 0);

    // Randomized mix against the model
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 2));
      case (op)
        0: do_load(int'($urandom_range(0, 15)));
        1: do_shift(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        default: do_seq(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
                        1'b1, 1'($urandom_range(0, 1)));
      endcase
    end

    // Scenario 1: reset asserted mid-run takes effect without a clock
    do_load(4'hB);
    start = 1'b1; dir = 1'b0; shiftCount = CW'(6);
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    m_reg = 0; m_dir = 0;
    check_all("midreset", 0, 0);
    tick();
    check_all("held_reset", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
